// File: rtl/check_gen.sv
// Result checker: pops a result/expect pair, masks and compares them, keeps
// pass/fail statistics and writes a multi-word result record over Avalon-MM.
//
// state | meaning
// IDLE  | waiting for both FIFOs to hold data
// RD    | one-cycle pop of RES_FIFO and CHECK_FIFO
// CMP   | FIFO data valid: compare, update stats, latch record and address
// WB    | write record words MSB-first, holding outputs while waitrequest
module check_gen #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int SCC_WIDTH   = 5,
  parameter int SCD_WIDTH   = 24,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH/8-1:0]             mem_byteenable,
  output logic                                mem_write,
  output logic [DATA_WIDTH-1:0]               mem_writedata,
  input  logic                                mem_waitrequest,
  input  logic [RTF_WIDTH+CYCLE_RANGE:0]      rfifo_data,
  output logic                                rfifo_rdreq,
  input  logic                                rfifo_rdempty,
  input  logic [2*RTF_WIDTH+ADDR_WIDTH-1:0]   cfifo_data,
  output logic                                cfifo_rdreq,
  input  logic                                cfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]                sc_cmd,
  input  logic [SCD_WIDTH-1:0]                sc_data,
  output logic                                sc_ready,
  output logic [CNT_WIDTH-1:0]                pass_count,
  output logic [CNT_WIDTH-1:0]                fail_count,
  output logic                                any_fail
);

  localparam int CHF_WIDTH  = 2*RTF_WIDTH + ADDR_WIDTH;
  localparam int RFF_WIDTH  = RTF_WIDTH + CYCLE_RANGE + 1;
  localparam int META_WIDTH = CYCLE_RANGE + 3;
  localparam int REC_WIDTH  = RTF_WIDTH + META_WIDTH;
  localparam int WORDS      = (REC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BUF_WIDTH  = WORDS * DATA_WIDTH;
  localparam int PAD        = BUF_WIDTH - REC_WIDTH;
  localparam int IDX_WIDTH  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS - 1);

  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK   = SCC_WIDTH'(1);
  localparam logic [SCC_WIDTH-1:0] CMD_MODE_ALL  = SCC_WIDTH'(2);
  localparam logic [SCC_WIDTH-1:0] CMD_MODE_FAIL = SCC_WIDTH'(3);
  localparam logic [SCC_WIDTH-1:0] CMD_CLR_STATS = SCC_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_WB} state_t;

  state_t                 state, state_nxt;
  logic [RTF_WIDTH-1:0]   bitmask;
  logic                   fail_only;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [BUF_WIDTH-1:0]   rec_q;
  logic                   rdreq;

  logic [RTF_WIDTH-1:0]   result_f, exp_f, dont_care_f, res_m, exp_m;
  logic [CYCLE_RANGE-1:0] cycles_f;
  logic                   timeout_f, fail_now;
  logic [ADDR_WIDTH-1:0]  caddr_f;
  logic [REC_WIDTH-1:0]   rec_raw;
  logic [BUF_WIDTH-1:0]   rec_next, rec_shift;
  logic                   unused_sc_data;

  assign result_f    = rfifo_data[RFF_WIDTH-1 -: RTF_WIDTH];
  assign cycles_f    = rfifo_data[CYCLE_RANGE:1];
  assign timeout_f   = rfifo_data[0];
  assign dont_care_f = cfifo_data[CHF_WIDTH-1 -: RTF_WIDTH];
  assign exp_f       = cfifo_data[ADDR_WIDTH+RTF_WIDTH-1 -: RTF_WIDTH];
  assign caddr_f     = cfifo_data[ADDR_WIDTH-1:0];

  assign res_m    = result_f & bitmask & ~dont_care_f;
  assign exp_m    = exp_f & bitmask & ~dont_care_f;
  assign fail_now = (res_m != exp_m);
  assign rec_raw  = {res_m, 1'b1, timeout_f, cycles_f, fail_now};
  assign rec_next = BUF_WIDTH'(rec_raw) << PAD;

  // Word 0 is the most significant slice of the left-justified record.
  assign rec_shift      = rec_q << (DATA_WIDTH * int'(idx_q));
  assign mem_writedata  = rec_shift[BUF_WIDTH-1 -: DATA_WIDTH];
  assign mem_address    = addr_q;
  assign mem_byteenable = '1;
  // Gated by reset so an aborted record never issues a write on the reset cycle.
  assign mem_write      = (state == S_WB) && !reset;
  assign rfifo_rdreq    = rdreq;
  assign cfifo_rdreq    = rdreq;
  assign sc_ready       = (state == S_IDLE) && rfifo_rdempty && cfifo_rdempty;
  assign unused_sc_data = ^sc_data;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdreq     = 1'b0;
    case (state)
      S_IDLE: if (!rfifo_rdempty && !cfifo_rdempty) state_nxt = S_RD;
      S_RD: begin
        rdreq     = 1'b1;
        state_nxt = S_CMP;
      end
      S_CMP:  state_nxt = (fail_only && !fail_now) ? S_IDLE : S_WB;
      S_WB:   if (!mem_waitrequest && idx_q == LAST_IDX) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitmask   <= '1;
      fail_only <= 1'b0;
    end else begin
      if (sc_cmd == CMD_BITMASK)   bitmask   <= sc_data[RTF_WIDTH-1:0];
      if (sc_cmd == CMD_MODE_ALL)  fail_only <= 1'b0;
      if (sc_cmd == CMD_MODE_FAIL) fail_only <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pass_count <= '0;
      fail_count <= '0;
      any_fail   <= 1'b0;
    end else if (sc_cmd == CMD_CLR_STATS) begin
      pass_count <= '0;
      fail_count <= '0;
      any_fail   <= 1'b0;
    end else if (state == S_CMP) begin
      if (fail_now) begin
        if (fail_count != '1) fail_count <= fail_count + 1'b1;
      end else if (pass_count != '1) begin
        pass_count <= pass_count + 1'b1;
      end
      any_fail <= any_fail | fail_now;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      idx_q  <= '0;
      rec_q  <= '0;
    end else if (state == S_CMP) begin
      addr_q <= caddr_f;
      idx_q  <= '0;
      rec_q  <= rec_next;
    end else if (state == S_WB && !mem_waitrequest) begin
      addr_q <= addr_q + 1'b1;
      idx_q  <= idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_check_gen.sv
// Directed bench for check_gen: FIFO models feed vectors, expected memory
// writes go into a scoreboard queue drained by an independent write monitor.
module tb_check_gen;

  localparam int AW = 20, DW = 16, RW = 24, CR = 5, CW = 2;
  localparam int RFW = RW + CR + 1;
  localparam int CFW = 2*RW + AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_waitrequest = 1'b0;
  logic [RFW-1:0] rfifo_data = '0;
  logic          rfifo_rdreq;
  logic          rfifo_rdempty = 1'b1;
  logic [CFW-1:0] cfifo_data = '0;
  logic          cfifo_rdreq;
  logic          cfifo_rdempty = 1'b1;
  logic [4:0]    sc_cmd = '0;
  logic [23:0]   sc_data = '0;
  logic          sc_ready;
  logic [CW-1:0] pass_count, fail_count;
  logic          any_fail;

  check_gen #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .pass_count(pass_count), .fail_count(fail_count), .any_fail(any_fail)
  );

  always #5 clock = ~clock;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t            sb[$];
  logic [RFW-1:0] rq[$];
  logic [CFW-1:0] cq[$];
  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  // Non-show-ahead FIFOs: data appears the cycle after rdreq.
  always @(posedge clock) begin
    if (rfifo_rdreq && rq.size() > 0) rfifo_data <= rq.pop_front();
    if (cfifo_rdreq && cq.size() > 0) cfifo_data <= cq.pop_front();
    rfifo_rdempty <= (rq.size() == 0);
    cfifo_rdempty <= (cq.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (mem_write && !mem_waitrequest) begin
      wr_t e;
      wr_count++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_address, mem_writedata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_address), 32'(e.a));
        check("wr_data", 32'(mem_writedata), 32'(e.d));
        check("byteenable", 32'(mem_byteenable), 32'h3);
      end
    end
  end

  task automatic send_cmd(input logic [4:0] c, input logic [23:0] d);
    @(negedge clock);
    sc_cmd = c; sc_data = d;
    @(negedge clock);
    sc_cmd = '0; sc_data = '0;
  endtask

  task automatic push_vec(input logic [23:0] r, input logic [4:0] cyc, input logic to,
                          input logic [23:0] e, input logic [23:0] dc, input logic [AW-1:0] a,
                          input logic wr, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    logic [AW-1:0] a1;
    a1 = a + 1'b1;
    if (wr) begin
      sb.push_back('{a: a, d: w0});
      sb.push_back('{a: a1, d: w1});
    end
    @(negedge clock);
    rq.push_back({r, cyc, to});
    cq.push_back({dc, e, a});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sc_ready && sb.size() == 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle with %0d writes pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input logic [23:0] r, input logic [4:0] cyc, input logic to,
                         input logic [23:0] e, input logic [23:0] dc, input logic [AW-1:0] a,
                         input logic wr, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    push_vec(r, cyc, to, e, dc, a, wr, w0, w1);
    repeat (3) @(negedge clock);
    wait_idle();
  endtask

  task automatic wait_sig_write(output bit ok);
    int n = 0;
    while (!mem_write && n < 50) begin @(negedge clock); n++; end
    ok = mem_write;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout: got mem_write 0 expected 1");
    end
  endtask

  initial begin
    bit ok;
    int n;
    int wr0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_pass", 32'(pass_count), 0);
    check("rst_fail", 32'(fail_count), 0);
    check("rst_any_fail", 32'(any_fail), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_rdreq", 32'({rfifo_rdreq, cfifo_rdreq}), 0);
    check("rst_sc_ready", 32'(sc_ready), 1);

    // Test 1: defaults, passing record
    run_vec(24'hA5A5A5, 5'd3, 1'b0, 24'hA5A5A5, 24'h0, 20'h00100, 1'b1, 16'hA5A5, 16'hA586);
    check("t1_pass", 32'(pass_count), 1);
    check("t1_fail", 32'(fail_count), 0);

    // Test 2: bitmask and dont_care hide bit 0; then a real failure
    send_cmd(5'd1, 24'hFFFFFE);
    run_vec(24'h000001, 5'd2, 1'b0, 24'h000000, 24'h0, 20'h00200, 1'b1, 16'h0000, 16'h0084);
    send_cmd(5'd1, 24'hFFFFFF);
    run_vec(24'h000001, 5'd2, 1'b1, 24'h000000, 24'h000001, 20'h00210, 1'b1, 16'h0000, 16'h00C4);
    check("t2_pass", 32'(pass_count), 3);
    check("t2_any_fail_clear", 32'(any_fail), 0);
    run_vec(24'h000001, 5'd5, 1'b0, 24'h000002, 24'h0, 20'h00220, 1'b1, 16'h0000, 16'h018B);
    check("t2_fail", 32'(fail_count), 1);
    check("t2_any_fail", 32'(any_fail), 1);

    // Test 3: fail-only writeback
    send_cmd(5'd4, 24'h0);
    check("t3_clr_pass", 32'(pass_count), 0);
    check("t3_clr_any", 32'(any_fail), 0);
    send_cmd(5'd3, 24'h0);
    wr0 = wr_count;
    run_vec(24'h123456, 5'd7, 1'b0, 24'h123456, 24'h0, 20'h00300, 1'b0, 16'h0, 16'h0);
    run_vec(24'h123456, 5'd31, 1'b1, 24'h123457, 24'h0, 20'h00310, 1'b1, 16'h1234, 16'h56FF);
    check("t3_writes", 32'(wr_count - wr0), 2);
    check("t3_pass", 32'(pass_count), 1);
    check("t3_fail", 32'(fail_count), 1);
    send_cmd(5'd2, 24'h0);

    // Test 4: stall on word 0, address wraps to 0 for word 1
    @(negedge clock);
    mem_waitrequest = 1'b1;
    wr0 = wr_count;
    push_vec(24'hFEDCBA, 5'd0, 1'b0, 24'hFEDCBA, 24'h0, 20'hFFFFF, 1'b1, 16'hFEDC, 16'hBA80);
    wait_sig_write(ok);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_addr", 32'(mem_address), 32'hFFFFF);
      check("t4_stall_data", 32'(mem_writedata), 32'hFEDC);
      @(posedge clock); #1;
    end
    mem_waitrequest = 1'b0;
    wait_idle();
    check("t4_writes", 32'(wr_count - wr0), 2);
    check("t4_sc_ready", 32'(sc_ready), 1);
    check("t4_pass", 32'(pass_count), 2);

    // Test 5: fail_count saturates at 3, then clear lands with a CMP increment
    for (int i = 0; i < 4; i++)
      run_vec(24'h000000, 5'd1, 1'b0, 24'h800000, 24'h0, 20'h00400 + 20'(2*i), 1'b1, 16'h0000, 16'h0083);
    check("t5_sat", 32'(fail_count), 3);
    push_vec(24'h000000, 5'd1, 1'b0, 24'h800000, 24'h0, 20'h00500, 1'b1, 16'h0000, 16'h0083);
    n = 0;
    while (!rfifo_rdreq && n < 50) begin @(negedge clock); n++; end
    check("t5_rdreq_seen", 32'(rfifo_rdreq), 1);
    @(negedge clock);
    sc_cmd = 5'd4;
    @(negedge clock);
    sc_cmd = 5'd0;
    wait_idle();
    check("t5_clr_fail", 32'(fail_count), 0);
    check("t5_clr_pass", 32'(pass_count), 0);
    check("t5_clr_any", 32'(any_fail), 0);

    // Test 6: reset after word 0 accepted aborts the record
    send_cmd(5'd1, 24'h000000);
    sb.push_back('{a: 20'h00600, d: 16'h0000});
    @(negedge clock);
    rq.push_back({24'h0F0F0F, 5'd2, 1'b0});
    cq.push_back({24'h0, 24'h0F0F0F, 20'h00600});
    wait_sig_write(ok);
    check("t6_pass_before", 32'(pass_count), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_mem_write", 32'(mem_write), 0);
    check("t6_sc_ready", 32'(sc_ready), 1);
    check("t6_pass", 32'(pass_count), 0);
    check("t6_fail", 32'(fail_count), 0);
    repeat (3) @(negedge clock);
    check("t6_no_more_writes", 32'(sb.size()), 0);
    sb.delete();
    run_vec(24'h000001, 5'd0, 1'b0, 24'h000000, 24'h0, 20'h00700, 1'b1, 16'h0000, 16'h0181);
    check("t6_bitmask_ones", 32'(fail_count), 1);

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
